// File: rtl/control_unit_pkg.sv
// Shared opcode map, field widths and decode bundle for the accumulator sequencer.
package control_unit_pkg;

    localparam int unsigned OPCODE_WIDTH  = 4;
    localparam int unsigned OPERAND_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_NOP = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_LD  = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_ST  = 4'h8,
        OP_JMP = 4'h9,
        OP_JZ  = 4'hA,
        OP_HLT = 4'hF
    } opcode_e;

    // 0xB..0xE are unassigned and execute as NOP while flagging illegal.
    function automatic logic op_defined(input logic [OPCODE_WIDTH-1:0] op);
        return !(op inside {[4'hB:4'hE]});
    endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Combinational opcode classifier feeding the control_unit EXEC strobes.
module instr_decoder
    import control_unit_pkg::*;
(
    input  logic [OPCODE_WIDTH-1:0] op,
    output logic                    is_alu,
    output logic                    is_carry,
    output logic                    is_store,
    output logic                    is_jump,
    output logic                    is_jz,
    output logic                    is_halt,
    output logic                    is_illegal
);

    always_comb begin
        is_alu     = 1'b0;
        is_carry   = 1'b0;
        is_store   = 1'b0;
        is_jump    = 1'b0;
        is_jz      = 1'b0;
        is_halt    = 1'b0;
        is_illegal = !op_defined(op);
        case (op)
            OP_ADD,
            OP_SUB: begin
                is_alu   = 1'b1;
                is_carry = 1'b1;
            end
            OP_LD,
            OP_AND,
            OP_OR,
            OP_XOR,
            OP_NOT: is_alu   = 1'b1;
            OP_ST:  is_store = 1'b1;
            OP_JMP: is_jump  = 1'b1;
            OP_JZ:  is_jz    = 1'b1;
            OP_HLT: is_halt  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Three-cycle fetch/latch/execute sequencer driving the accumulator ALU and register file.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 4,
    parameter int unsigned INSTR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    output logic [PC_WIDTH-1:0]     prog_addr,
    input  logic [INSTR_WIDTH-1:0]  prog_data,
    input  logic                    acc_zero,
    output logic [OPCODE_WIDTH-1:0] opcode,
    output logic                    alu_ce,
    output logic                    cy_ce,
    output logic [3:0]              reg_sel,
    output logic                    reg_we,
    output logic                    busy,
    output logic                    halted,
    output logic                    illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EXEC,
        S_HALTED
    } state_e;

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   illegal_q, illegal_d;

    logic is_alu, is_carry, is_store, is_jump, is_jz, is_halt, is_illegal;
    logic [PC_WIDTH-1:0] pc_inc, jump_target;

    assign opcode      = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    assign reg_sel     = ir_q[OPERAND_WIDTH-1:0];
    assign prog_addr   = pc_q;
    assign illegal     = illegal_q;
    assign pc_inc      = pc_q + PC_WIDTH'(1);
    assign jump_target = PC_WIDTH'(ir_q[OPERAND_WIDTH-1:0]);

    instr_decoder u_dec (
        .op         (opcode),
        .is_alu     (is_alu),
        .is_carry   (is_carry),
        .is_store   (is_store),
        .is_jump    (is_jump),
        .is_jz      (is_jz),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes decode from the registered state so an async reset kills them at once.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        alu_ce    = 1'b0;
        cy_ce     = 1'b0;
        reg_we    = 1'b0;
        busy      = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            S_FETCH: begin
                busy    = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                busy    = 1'b1;
                ir_d    = prog_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                busy   = 1'b1;
                alu_ce = is_alu;
                cy_ce  = is_carry;
                reg_we = is_store;
                if (is_illegal) begin
                    illegal_d = 1'b1;
                end
                if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                    if (is_jump || (is_jz && acc_zero)) begin
                        pc_d = jump_target;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            S_HALTED: begin
                halted = 1'b1;
                if (run) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
